// File: rtl/btb_update_ctrl_pkg.sv
// Shared types for the BTB write-side controller.
// Holds the address bus type, reset level, FSM encoding and queue entry.
package btb_update_ctrl_pkg;

    localparam int INST_ADDR_W = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    // Active level of the synchronous reset input.
    localparam logic RESET_ENABLE = 1'b1;

    typedef enum logic {
        BTBC_SWEEP = 1'b0,
        BTBC_RUN   = 1'b1
    } btbc_state_t;

    // One resolved branch waiting for the BTB write port.
    typedef struct packed {
        inst_addr_t pc;
        inst_addr_t target;
        logic       taken;
    } upd_entry_t;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Bundle between execute/fetch and the BTB update controller.
// master: branch resolution + BTB side; slave: the controller.
interface btb_update_ctrl_if #(
    parameter int BUFFER_ADDR_LEN = 12,
    parameter int CNT_W           = 16
);
    import btb_update_ctrl_pkg::*;

    logic                       flush_i;
    logic                       upd_valid_i;
    logic                       upd_ready_o;
    inst_addr_t                 upd_pc_i;
    inst_addr_t                 upd_target_i;
    logic                       upd_taken_i;

    logic                       btb_wr_en_o;
    logic                       btb_wr_valid_o;
    logic [BUFFER_ADDR_LEN-1:0] btb_wr_idx_o;
    inst_addr_t                 btb_wr_pc_o;
    inst_addr_t                 btb_wr_target_o;
    logic                       btb_wr_state_o;
    logic                       btb_ready_o;
    logic [CNT_W-1:0]           upd_count_o;

    modport master (
        output flush_i,
        output upd_valid_i,
        output upd_pc_i,
        output upd_target_i,
        output upd_taken_i,
        input  upd_ready_o,
        input  btb_wr_en_o,
        input  btb_wr_valid_o,
        input  btb_wr_idx_o,
        input  btb_wr_pc_o,
        input  btb_wr_target_o,
        input  btb_wr_state_o,
        input  btb_ready_o,
        input  upd_count_o
    );

    modport slave (
        input  flush_i,
        input  upd_valid_i,
        input  upd_pc_i,
        input  upd_target_i,
        input  upd_taken_i,
        output upd_ready_o,
        output btb_wr_en_o,
        output btb_wr_valid_o,
        output btb_wr_idx_o,
        output btb_wr_pc_o,
        output btb_wr_target_o,
        output btb_wr_state_o,
        output btb_ready_o,
        output upd_count_o
    );

endinterface

// File: rtl/btb_update_ctrl_fifo.sv
// btb_upd_fifo: synchronous queue of resolved-branch updates.
// Ports: clk/rst, flush, push valid/ready/data, pop strobe, head valid/data.
module btb_upd_fifo
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push_valid,
    output logic       push_ready,
    input  upd_entry_t push_data,
    input  logic       pop,
    output logic       head_valid,
    output upd_entry_t head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] OCC_ONE = 1;
    localparam logic [CW-1:0] OCC_MAX = CW'(DEPTH);

    upd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full  = (occ == OCC_MAX);
    assign empty = (occ == '0);

    // Readiness depends only on fullness, so a pop in the same
    // cycle never lets a push into a full queue.
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop && !empty;

    assign head_valid = !empty;
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: sequences every write into the BTB.
// Ports: clk_i, rst_i (sync, active-high) and the bus interface (slave):
//   update input handshake + flush, BTB write port, btb_ready, update count.
// After reset/flush all entries are cleared by a sweep; afterwards queued
// branch updates drain at one per cycle.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int BUFFER_ADDR_LEN = 12,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    btb_update_ctrl_if.slave bus
);

    localparam logic [BUFFER_ADDR_LEN-1:0] IDX_ONE = 1;
    localparam logic [CNT_W-1:0]           CNT_ONE = 1;

    btbc_state_t state;
    btbc_state_t state_nxt;

    logic [BUFFER_ADDR_LEN-1:0] sweep_idx;
    logic                       sweep_last;

    logic       fifo_ready;
    logic       fifo_pop;
    logic       head_valid;
    upd_entry_t head;
    upd_entry_t push_data;
    logic       accept;

    logic [CNT_W-1:0] upd_count;

    logic                       wr_en;
    logic                       wr_valid;
    logic [BUFFER_ADDR_LEN-1:0] wr_idx;
    inst_addr_t                 wr_pc;
    inst_addr_t                 wr_target;
    logic                       wr_state;
    logic                       ready;

    assign sweep_last = (sweep_idx == '1);

    assign push_data.pc     = bus.upd_pc_i;
    assign push_data.target = bus.upd_target_i;
    assign push_data.taken  = bus.upd_taken_i;

    // A flush drops an update offered in the same cycle.
    assign accept = bus.upd_valid_i && fifo_ready && !bus.flush_i;

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (bus.flush_i),
        .push_valid (bus.upd_valid_i),
        .push_ready (fifo_ready),
        .push_data  (push_data),
        .pop        (fifo_pop),
        .head_valid (head_valid),
        .head_data  (head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE) begin
            state <= BTBC_SWEEP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BTBC_SWEEP: begin
                if (sweep_last) begin
                    state_nxt = BTBC_RUN;
                end
            end
            BTBC_RUN: begin
                state_nxt = BTBC_RUN;
            end
        endcase
        if (bus.flush_i) begin
            state_nxt = BTBC_SWEEP;
        end
    end

    // The index rolls to zero on the last sweep write, which is also
    // where the FSM leaves SWEEP, so no second pass ever starts.
    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE || bus.flush_i) begin
            sweep_idx <= '0;
        end else if (state == BTBC_SWEEP) begin
            sweep_idx <= sweep_last ? '0 : sweep_idx + IDX_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE) begin
            upd_count <= '0;
        end else if (accept && upd_count != '1) begin
            upd_count <= upd_count + CNT_ONE;
        end
    end

    // Write port is driven straight from the sweep index or FIFO head;
    // everything is held quiet while reset is asserted.
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = 1'b0;
        wr_idx    = '0;
        wr_pc     = '0;
        wr_target = '0;
        wr_state  = 1'b0;
        ready     = 1'b0;
        fifo_pop  = 1'b0;
        if (rst_i != RESET_ENABLE) begin
            unique case (state)
                BTBC_SWEEP: begin
                    wr_en  = 1'b1;
                    wr_idx = sweep_idx;
                end
                BTBC_RUN: begin
                    ready = 1'b1;
                    if (head_valid) begin
                        fifo_pop  = 1'b1;
                        wr_en     = 1'b1;
                        wr_valid  = 1'b1;
                        wr_idx    = head.pc[BUFFER_ADDR_LEN+1:2];
                        wr_pc     = head.pc;
                        wr_target = head.target;
                        wr_state  = head.taken;
                    end
                end
            endcase
        end
    end

    assign bus.upd_ready_o     = fifo_ready;
    assign bus.btb_wr_en_o     = wr_en;
    assign bus.btb_wr_valid_o  = wr_valid;
    assign bus.btb_wr_idx_o    = wr_idx;
    assign bus.btb_wr_pc_o     = wr_pc;
    assign bus.btb_wr_target_o = wr_target;
    assign bus.btb_wr_state_o  = wr_state;
    assign bus.btb_ready_o     = ready;
    assign bus.upd_count_o     = upd_count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Testbench for btb_update_ctrl: directed steps plus random traffic,
// checked against a queue-based reference model.
module tb_btb_update_ctrl;
    import btb_update_ctrl_pkg::*;

    localparam int AL     = 4;
    localparam int FD     = 4;
    localparam int CW     = 5;
    localparam int NSWEEP = 16;
    localparam int CMAX   = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    btb_update_ctrl_if #(.BUFFER_ADDR_LEN(AL), .CNT_W(CW)) bus ();

    btb_update_ctrl #(
        .BUFFER_ADDR_LEN (AL),
        .FIFO_DEPTH      (FD),
        .CNT_W           (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: sweeping flag + position, pending queue, count.
    bit         m_sweep;
    int         m_pos;
    upd_entry_t m_q[$];
    int         m_cnt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives, checks, clocks, advances model.
    task automatic tick(bit fl, bit v, logic [31:0] pc,
                        logic [31:0] tg, bit tk);
        bit         acc;
        upd_entry_t e;
        bus.flush_i      = fl;
        bus.upd_valid_i  = v;
        bus.upd_pc_i     = pc;
        bus.upd_target_i = tg;
        bus.upd_taken_i  = tk;
        #1;
        if (m_sweep) begin
            chk("sweep_en", bus.btb_wr_en_o, 1);
            chk("sweep_valid", bus.btb_wr_valid_o, 0);
            chk("sweep_idx", bus.btb_wr_idx_o, m_pos);
            chk("sweep_pc", bus.btb_wr_pc_o, 0);
            chk("sweep_tgt", bus.btb_wr_target_o, 0);
            chk("sweep_state", bus.btb_wr_state_o, 0);
        end else if (m_q.size() > 0) begin
            chk("drain_en", bus.btb_wr_en_o, 1);
            chk("drain_valid", bus.btb_wr_valid_o, 1);
            chk("drain_idx", bus.btb_wr_idx_o, (m_q[0].pc >> 2) % NSWEEP);
            chk("drain_pc", bus.btb_wr_pc_o, m_q[0].pc);
            chk("drain_tgt", bus.btb_wr_target_o, m_q[0].target);
            chk("drain_state", bus.btb_wr_state_o, m_q[0].taken);
        end else begin
            chk("idle_en", bus.btb_wr_en_o, 0);
        end
        chk("btb_ready", bus.btb_ready_o, !m_sweep);
        chk("upd_ready", bus.upd_ready_o, m_q.size() < FD);
        chk("upd_count", bus.upd_count_o, m_cnt);
        @(posedge clk);
        if (fl) begin
            m_sweep = 1'b1;
            m_pos   = 0;
            m_q.delete();
        end else begin
            acc = v && (m_q.size() < FD);
            if (!m_sweep && m_q.size() > 0) begin
                void'(m_q.pop_front());
            end
            if (acc) begin
                e.pc     = pc;
                e.target = tg;
                e.taken  = tk;
                m_q.push_back(e);
                if (m_cnt < CMAX) m_cnt++;
            end
            if (m_sweep) begin
                if (m_pos == NSWEEP - 1) m_sweep = 1'b0;
                else m_pos++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(int n);
        rst              = 1'b1;
        bus.flush_i      = 1'b0;
        bus.upd_valid_i  = 1'b1;
        bus.upd_pc_i     = 32'h44;
        bus.upd_target_i = 32'h88;
        bus.upd_taken_i  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("rst_wr_en", bus.btb_wr_en_o, 0);
        chk("rst_wr_valid", bus.btb_wr_valid_o, 0);
        chk("rst_wr_idx", bus.btb_wr_idx_o, 0);
        chk("rst_btb_ready", bus.btb_ready_o, 0);
        chk("rst_upd_ready", bus.upd_ready_o, 1);
        chk("rst_count", bus.upd_count_o, 0);
        rst     = 1'b0;
        m_sweep = 1'b1;
        m_pos   = 0;
        m_cnt   = 0;
        m_q.delete();
    endtask

    initial begin
        logic [31:0] rpc;
        bus.flush_i      = 1'b0;
        bus.upd_valid_i  = 1'b0;
        bus.upd_pc_i     = '0;
        bus.upd_target_i = '0;
        bus.upd_taken_i  = 1'b0;
        @(negedge clk);

        // Power-up sweep, then one update in RUN.
        do_reset(2);
        idle(NSWEEP);
        tick(0, 1, 32'h0000_0040, 32'h0000_0100, 1);
        #1;
        chk("tp2_en", bus.btb_wr_en_o, 1);
        chk("tp2_idx", bus.btb_wr_idx_o, 0);
        chk("tp2_tgt", bus.btb_wr_target_o, 32'h100);
        chk("tp2_state", bus.btb_wr_state_o, 1);
        chk("tp2_count", bus.upd_count_o, 1);
        idle(2);

        // Fill the queue during the sweep; the fifth is refused.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 32'h1000 + 4 * i, 32'h2000 + i, i[0]);
        end
        idle(NSWEEP - 5 + 5);
        chk("tp3_count", bus.upd_count_o, 4);

        // Flush on the last sweep cycle with two updates pending.
        do_reset(1);
        idle(NSWEEP - 3);
        tick(0, 1, 32'h0000_0a08, 32'h0000_0b00, 1);
        tick(0, 1, 32'h0000_0c0c, 32'h0000_0d00, 0);
        tick(1, 1, 32'h0000_0e10, 32'h0000_0f00, 1);
        idle(NSWEEP + 3);
        chk("tp4_count", bus.upd_count_o, 2);

        // Flush in mid-sweep restarts at index 0.
        tick(1, 0, 0, 0, 0);
        idle(9);
        tick(1, 0, 0, 0, 0);
        #1;
        chk("tp5_restart_idx", bus.btb_wr_idx_o, 0);
        idle(NSWEEP + 1);

        // Back-to-back pushes in RUN never stall.
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        idle(2);

        // Random traffic with occasional flushes and one reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(1);
            rpc = $urandom;
            tick($urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0,
                 rpc, $urandom, 1'($urandom_range(0, 1)));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
